// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-to-1 round-robin arbitrating mux with one registered output stage.
// Merges NUM_CH valid/ready request channels onto a single downstream port.
// The search for a grant starts at rr_ptr and wraps NUM_CH-1 -> 0. rr_ptr then
// moves to the slot just past the granted channel, so with every channel
// continuously valid the grants rotate through all channels.
// Optional feature: define RR_ARB_MUX_FORCE_SEL_EN to add force_en/force_sel.
// These turn the block into a registered static mux that selects force_sel.

// Per-channel lane: turns the shared grant vector into this channel's accept,
// and gates its payload so the top can OR all lanes together.
module rr_arb_mux_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_gnt,
  input  logic                  i_load,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic w_sel;

  // The grant already implies i_valid. The extra AND keeps in_ready from
  // rising on an idle lane.
  always_comb begin
    w_sel   = i_gnt & i_valid;
    o_ready = w_sel & i_load;
    o_data  = w_sel ? i_data : '0;
  end

endmodule

module rr_arb_mux #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int SEL_W      = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
`ifdef RR_ARB_MUX_FORCE_SEL_EN
  input  logic                         force_en,
  input  logic [SEL_W-1:0]             force_sel,
`endif
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]             out_sel,
  input  logic                         out_ready
);

  logic                              r_out_valid;
  logic [DATA_WIDTH-1:0]             r_out_data;
  logic [SEL_W-1:0]                  r_out_sel;
  logic [SEL_W-1:0]                  r_rr_ptr;

  logic                              w_load;
  logic                              w_any;
  logic                              w_hold_ptr;
  logic [SEL_W-1:0]                  w_gnt_idx;
  logic [NUM_CH-1:0]                 w_gnt;
  logic [NUM_CH-1:0]                 w_lane_rdy;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_lane_data;
  logic [DATA_WIDTH-1:0]             w_mux_data;

  // The register can take a new beat when it is empty or is draining this cycle.
  assign w_load = ~r_out_valid | out_ready;

  // Rotating-priority search for the first valid channel at or after rr_ptr.
  // The index wraps by subtraction rather than by a bit mask, so NUM_CH does
  // not have to be a power of two.
  always_comb begin
    int   idx;
    logic found;
    w_gnt      = '0;
    w_gnt_idx  = '0;
    w_any      = 1'b0;
    w_hold_ptr = 1'b0;
    found      = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && in_valid[idx]) begin
        found     = 1'b1;
        w_gnt_idx = SEL_W'(idx);
      end
    end
`ifdef RR_ARB_MUX_FORCE_SEL_EN
    if (force_en) begin
      // Static mux mode: only force_sel can win. An index that is out of
      // range grants nothing. The pointer stays frozen so that round-robin
      // resumes where it left off.
      w_hold_ptr = 1'b1;
      found      = 1'b0;
      w_gnt_idx  = force_sel;
      if (int'(force_sel) < NUM_CH) found = in_valid[force_sel];
    end
`endif
    w_any = found;
    if (found) w_gnt[w_gnt_idx] = 1'b1;
  end

  // Per-channel ready and payload gating.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      rr_arb_mux_lane #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_lane (
        .i_gnt   (w_gnt[gi]),
        .i_load  (w_load),
        .i_valid (in_valid[gi]),
        .i_data  (in_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .o_ready (w_lane_rdy[gi]),
        .o_data  (w_lane_data[gi])
      );
    end
  endgenerate

  // AND-OR mux: only the granted lane contributes non-zero data.
  always_comb begin
    w_mux_data = '0;
    for (int i = 0; i < NUM_CH; i++) w_mux_data = w_mux_data | w_lane_data[i];
  end

  // No channel is accepted while reset is held.
  assign in_ready = rst ? '0 : w_lane_rdy;

  // Output stage and round-robin pointer. The pointer moves only on a
  // transfer. An idle load empties the register but keeps the last data and
  // sel visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_data;
        r_out_sel   <= w_gnt_idx;
        if (!w_hold_ptr) begin
          if (int'(w_gnt_idx) == NUM_CH - 1) r_rr_ptr <= '0;
          else                               r_rr_ptr <= w_gnt_idx + SEL_W'(1);
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
